// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: RV32I decoder driving ALUOp/operand selects behind a one-entry valid/ready stage.
module alu_ctrl_decode #(
    parameter int         XLEN       = 32,
    parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic            a_sel_pc,
    output logic            b_sel_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic [2:0]      funct3,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            a_sel_pc;
        logic            b_sel_imm;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state, state_nxt;
    bundle_t    dec, q;
    logic       bad, capture;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.rs1    = instr[19:15];
        dec.rd     = instr[11:7];
        dec.funct3 = f3;
        dec.pc     = pc_in;
        case (opc)
            OP_R: begin
                dec.alu_op    = {f7[5], f3};
                dec.rs2       = instr[24:20];
                dec.reg_write = 1'b1;
                bad = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_I: begin
                dec.alu_op    = {f3 == 3'b101 && f7[5], f3};
                dec.b_sel_imm = 1'b1;
                dec.imm       = f3[1:0] == 2'b01 ? {27'b0, instr[24:20]} : imm_i;
                dec.reg_write = 1'b1;
                bad = (f3 == 3'b001 && f7 != 7'b0) ||
                      (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
            end
            LOAD: begin
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            STORE: begin
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_s;
                dec.rs2       = instr[24:20];
                dec.mem_write = 1'b1;
            end
            BRANCH: begin
                // eq/ne compare by subtraction, lt/ge by signed or unsigned set-less-than
                dec.alu_op = f3[2] ? {3'b001, f3[1]} : 4'b1000;
                dec.imm    = imm_b;
                dec.rs2    = instr[24:20];
                dec.branch = 1'b1;
                bad        = f3[2:1] == 2'b01;
            end
            LUI: begin
                dec.alu_op    = 4'b1111;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            AUIPC: begin
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            JAL: begin
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_j;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            JALR: begin
                dec.b_sel_imm = 1'b1;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                bad           = f3 != 3'b000;
            end
            default: bad = 1'b1;
        endcase
        dec.illegal = bad;
        dec.alu_op  = bad ? ILLEGAL_OP : dec.alu_op;
        {dec.mem_read, dec.mem_write, dec.branch, dec.jump} =
            bad ? 4'b0 : {dec.mem_read, dec.mem_write, dec.branch, dec.jump};
        dec.reg_write = dec.reg_write && !bad && dec.rd != 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        capture   = in_valid && in_ready && !flush;
        state_nxt = flush ? EMPTY : capture ? FULL : out_ready ? EMPTY : state;
    end

    always_comb begin
        out_valid = state == FULL;
        in_ready  = state == EMPTY || out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q <= '0;
        else if (capture) q <= dec;
    end

    assign {alu_op, a_sel_pc, b_sel_imm, imm, rs1, rs2, rd, reg_write, mem_read,
            mem_write, branch, jump, funct3, illegal, pc_out} = q;
endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb_alu_ctrl_decode: directed vectors for decode, handshake, flush and async reset.
module tb_alu_ctrl_decode;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] instr = '0, pc_in = '0;
    logic        in_ready, out_valid, a_sel_pc, b_sel_imm, reg_write, mem_read, mem_write;
    logic        branch, jump, illegal;
    logic [3:0]  alu_op;
    logic [31:0] imm, pc_out;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    int          total = 0, passed = 0;
    logic [11:0] ctl;
    logic [93:0] all_out;

    assign ctl     = {alu_op, a_sel_pc, b_sel_imm, reg_write, mem_read, mem_write, branch, jump, illegal};
    assign all_out = {ctl, imm, rs1, rs2, rd, funct3, pc_out};

    always #5 clk = ~clk;

    alu_ctrl_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .a_sel_pc(a_sel_pc), .b_sel_imm(b_sel_imm), .imm(imm), .rs1(rs1),
        .rs2(rs2), .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .funct3(funct3), .illegal(illegal), .pc_out(pc_out)
    );

    typedef struct {
        logic [31:0] ins;
        logic [11:0] ctl;
        logic [11:0] cmask;
        logic [31:0] imm;
        logic        ichk;
        logic [14:0] regs;
        logic [14:0] rmask;
    } vec_t;

    task automatic issue(input logic [31:0] i, input logic [31:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = i;
        pc_in    = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else passed++;
        total++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode;
        vec_t tv[15];
        tv = '{
            '{32'h402081B3, 12'h820, 12'hFFF, 32'h0,        1'b0, {5'd1, 5'd2, 5'd3}, 15'h7FFF},
            '{32'h40335293, 12'hD60, 12'hFFF, 32'h3,        1'b1, {5'd6, 5'd0, 5'd5}, 15'h7FFF},
            '{32'h123450B7, 12'hF60, 12'hFFF, 32'h12345000, 1'b1, {5'd0, 5'd0, 5'd1}, 15'h03FF},
            '{32'h00208033, 12'h000, 12'hFFF, 32'h0,        1'b0, {5'd1, 5'd2, 5'd0}, 15'h7FFF},
            '{32'hFFF14093, 12'h460, 12'hFFF, 32'hFFFFFFFF, 1'b1, {5'd2, 5'd0, 5'd1}, 15'h7FFF},
            '{32'hFE20ECE3, 12'h304, 12'hFFF, 32'hFFFFFFF8, 1'b1, {5'd1, 5'd2, 5'd0}, 15'h7FE0},
            '{32'h00812283, 12'h070, 12'hFFF, 32'h8,        1'b1, {5'd2, 5'd0, 5'd5}, 15'h7FFF},
            '{32'hFE612E23, 12'h048, 12'hFFF, 32'hFFFFFFFC, 1'b1, {5'd2, 5'd6, 5'd0}, 15'h7FE0},
            '{32'h010000EF, 12'h0E2, 12'hFFF, 32'h10,       1'b1, {5'd0, 5'd0, 5'd1}, 15'h03FF},
            '{32'h004100E7, 12'h062, 12'hFFF, 32'h4,        1'b1, {5'd2, 5'd0, 5'd1}, 15'h7FFF},
            '{32'h00001217, 12'h0E0, 12'hFFF, 32'h1000,     1'b1, {5'd0, 5'd0, 5'd4}, 15'h03FF},
            '{32'hFFFFFFFF, 12'h001, 12'hF3F, 32'h0,        1'b0, 15'h0,              15'h0},
            '{32'h000110E7, 12'h001, 12'hF3F, 32'h0,        1'b0, 15'h0,              15'h0},
            '{32'h4020F1B3, 12'h001, 12'hF3F, 32'h0,        1'b0, 15'h0,              15'h0},
            '{32'h02335293, 12'h001, 12'hF3F, 32'h0,        1'b0, 15'h0,              15'h0}
        };
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            logic [31:0] p;
            logic [2:0]  f;
            logic [31:0] w;
            p = 32'h1000 + 32'(k * 4);
            w = tv[k].ins;
            f = w[14:12];
            issue(tv[k].ins, p);
            total++;
            if (out_valid !== 1'b1 || pc_out !== p)
                $display("FAIL dec%0d_valid_pc: valid=%b pc=%h want 1/%h", k, out_valid, pc_out, p);
            else passed++;
            total++;
            if ((ctl & tv[k].cmask) !== tv[k].ctl)
                $display("FAIL dec%0d_ctl: got %h want %h", k, ctl & tv[k].cmask, tv[k].ctl);
            else passed++;
            total++;
            if (funct3 !== f) $display("FAIL dec%0d_funct3: got %b want %b", k, funct3, f);
            else passed++;
            if (tv[k].ichk) begin
                total++;
                if (imm !== tv[k].imm) $display("FAIL dec%0d_imm: got %h want %h", k, imm, tv[k].imm);
                else passed++;
            end
            if (tv[k].rmask != 15'h0) begin
                total++;
                if (({rs1, rs2, rd} & tv[k].rmask) !== tv[k].regs)
                    $display("FAIL dec%0d_regs: got %h want %h", k, {rs1, rs2, rd} & tv[k].rmask, tv[k].regs);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        issue(32'h402081B3, 32'h100);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h123450B7;
        pc_in     = 32'h104;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready);
        else passed++;
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, in_ready, alu_op, pc_out} !== {1'b1, 1'b0, 4'b1000, 32'h100})
                $display("FAIL stall_hold: valid=%b in_ready=%b op=%b pc=%h want 1/0/1000/100",
                         out_valid, in_ready, alu_op, pc_out);
            else passed++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, alu_op, pc_out} !== {1'b1, 4'b1111, 32'h104})
            $display("FAIL release_b: valid=%b op=%b pc=%h want 1/1111/104", out_valid, alu_op, pc_out);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        issue(32'h402081B3, 32'h200);
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h123450B7;
        pc_in     = 32'h204;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL flush_kill: got %b want 0", out_valid);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_capture: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 1'b0;
        issue(32'hFE20ECE3, 32'h300);
        total++;
        if (out_valid !== 1'b1 || branch !== 1'b1)
            $display("FAIL areset_setup: valid=%b branch=%b want 1/1", out_valid, branch);
        else passed++;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || all_out !== '0)
            $display("FAIL areset_clear: valid=%b outs=%h want 0/0", out_valid, all_out);
        else passed++;
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL areset_stays_empty: got %b want 0", out_valid);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_decode;
        test_back_to_back;
        test_flush;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
